// File: rtl/tsc_pkg.sv
// Shared TSC definitions: default word size, arbiter FSM encoding, channel ids.
// Used by tsc_mem_arbiter and tsc_rr_pick.
package tsc_pkg;

   localparam int unsigned WORD_SIZE_DEF = 16;

   // Fixed channel roles on the memory arbiter
   localparam int unsigned CH_FETCH = 0;
   localparam int unsigned CH_DATA  = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Index width for an n-entry vector, never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/tsc_rr_pick.sv
// Combinational round-robin picker: returns the first requester found
// searching upward (mod NUM_CH) from ptr+1, so the channel at ptr is last.
module tsc_rr_pick
   import tsc_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [IDX_W-1:0]  winner,
   output logic              valid
);

   // Descending scan so the hit closest to ptr+1 is the last one written
   always_comb begin
      int unsigned idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int unsigned k = NUM_CH; k >= 1; k--) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (req[idx[IDX_W-1:0]]) begin
            winner = IDX_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tsc_mem_arbiter.sv
// TSC memory-port controller: round-robin arbitration of NUM_CH requesters
// onto one external memory port, one read or write outstanding at a time.
// Optional handshake watchdog enabled by defining TSC_MEMARB_TIMEOUT_EN.
module tsc_mem_arbiter
   import tsc_pkg::*;
#(
   parameter int unsigned WORD_SIZE      = WORD_SIZE_DEF,
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_CH-1:0]           req,
   input  logic [NUM_CH-1:0]           we,
   input  logic [NUM_CH*WORD_SIZE-1:0] addr,
   input  logic [NUM_CH*WORD_SIZE-1:0] wdata,
   output logic [WORD_SIZE-1:0]        rdata,
   output logic [NUM_CH-1:0]           done,
   output logic                        err,
   output logic                        busy,
   output logic                        readM,
   output logic                        writeM,
   output logic [WORD_SIZE-1:0]        address,
   inout  wire  [WORD_SIZE-1:0]        data,
   input  logic                        inputReady,
   input  logic                        ackOutput
);

   localparam int unsigned IDX_W = idx_width(NUM_CH);

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      ch_q, ch_d;
   logic                  we_q, we_d;
   logic [WORD_SIZE-1:0]  wdata_q, wdata_d;

   logic [IDX_W-1:0]      win_c;
   logic                  win_valid_c;
   logic [NUM_CH-1:0]     req_eff_c;
   logic [NUM_CH-1:0]     ch_mask_c;
   logic                  handshake_c;
   logic                  timeout_c;
   logic                  complete_c;

   logic [WORD_SIZE-1:0]  rdata_d;
   logic [WORD_SIZE-1:0]  address_d;
   logic [NUM_CH-1:0]     done_d;
   logic                  err_d;
   logic                  busy_d;
   logic                  readm_d;
   logic                  writem_d;

   // Only the handshake matching the current direction counts
   assign handshake_c = we_q ? ackOutput : inputReady;
   assign complete_c  = (state_q == ST_BUSY) && (handshake_c || timeout_c);
   assign ch_mask_c   = NUM_CH'(1) << ch_q;

   // Memory data bus is driven only while the write strobe is up
   assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

   // Eligible requests: all in IDLE; on the completion edge all but the finishing channel
   always_comb begin
      req_eff_c = '0;
      if (state_q == ST_IDLE) begin
         req_eff_c = req;
      end else if (complete_c) begin
         req_eff_c = req & ~ch_mask_c;
      end
   end

   tsc_rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req    (req_eff_c),
      .ptr    (ptr_q),
      .winner (win_c),
      .valid  (win_valid_c)
   );

`ifdef TSC_MEMARB_TIMEOUT_EN
   localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;

   // BUSY cycle counter, restarted by every grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
      end else if (win_valid_c) begin
         tmo_cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
         tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
   end

   assign timeout_c = (state_q == ST_BUSY) &&
                      (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a completion edge may grant the next channel directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid_c) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (complete_c) begin
               state_d = win_valid_c ? ST_BUSY : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and the latched transaction
   always_comb begin
      ptr_d     = ptr_q;
      ch_d      = ch_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata;
      address_d = address;
      done_d    = '0;
      err_d     = 1'b0;
      busy_d    = 1'b0;
      readm_d   = 1'b0;
      writem_d  = 1'b0;

      if (state_q == ST_BUSY) begin
         if (complete_c) begin
            done_d = ch_mask_c;
            err_d  = timeout_c && !handshake_c;
            if (handshake_c && !we_q) begin
               rdata_d = data;
            end
         end else begin
            readm_d  = !we_q;
            writem_d = we_q;
            busy_d   = 1'b1;
         end
      end

      if (win_valid_c) begin
         ptr_d     = win_c;
         ch_d      = win_c;
         we_d      = we[win_c];
         address_d = addr[32'(win_c)*WORD_SIZE +: WORD_SIZE];
         wdata_d   = wdata[32'(win_c)*WORD_SIZE +: WORD_SIZE];
         readm_d   = !we[win_c];
         writem_d  = we[win_c];
         busy_d    = 1'b1;
      end
   end

   // Output and transaction registers; reset aborts silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q   <= IDX_W'(NUM_CH - 1);
         ch_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata   <= '0;
         address <= '0;
         done    <= '0;
         err     <= 1'b0;
         busy    <= 1'b0;
         readM   <= 1'b0;
         writeM  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata   <= rdata_d;
         address <= address_d;
         done    <= done_d;
         err     <= err_d;
         busy    <= busy_d;
         readM   <= readm_d;
         writeM  <= writem_d;
      end
   end

endmodule
